ass13_resp_misr: RTL and testbench



---
 rtl/ass13_resp_misr.sv | 102 ++++++++++
 tb/tb_ass13_resp_misr.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ass13_resp_misr.sv
// Response compactor for the ass13 controller: folds a window of 25-bit output
// vectors into a 32-bit MISR signature, counts all-zero vectors and checks a golden value.
module ass13_resp_misr #(
   parameter int unsigned WINDOW = 64,
   parameter logic [31:0] POLY   = 32'h04C11DB7,
   parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [24:0] y_in,
   input  logic        y_valid,
   input  logic [31:0] golden,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] signature,
   output logic [15:0] sample_cnt,
   output logic [15:0] zero_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [15:0] LAST_CNT = 16'(WINDOW - 1);

   state_t      state_q, state_d;
   logic [31:0] sig_q, sig_d;
   logic [15:0] sample_cnt_q, sample_cnt_d;
   logic [15:0] zero_cnt_q, zero_cnt_d;
   logic        pass_q, pass_d;

   logic [31:0] sig_next;
   logic        accept;
   logic        last_sample;
   logic        load;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sig_q        <= SEED;
         sample_cnt_q <= '0;
         zero_cnt_q   <= '0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sig_q        <= sig_d;
         sample_cnt_q <= sample_cnt_d;
         zero_cnt_q   <= zero_cnt_d;
         pass_q       <= pass_d;
      end
   end

   always_comb begin
      accept      = (state_q == RUN) && y_valid;
      last_sample = accept && (sample_cnt_q == LAST_CNT);
      // A start in DONE is honoured exactly like one in IDLE.
      load        = (state_q != RUN) && start;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_sample) state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sig_next     = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : '0) ^ {7'b0, y_in};
      sig_d        = sig_q;
      sample_cnt_d = sample_cnt_q;
      zero_cnt_d   = zero_cnt_q;
      pass_d       = pass_q;
      if (load) begin
         sig_d        = SEED;
         sample_cnt_d = '0;
         zero_cnt_d   = '0;
         pass_d       = 1'b0;
      end else if (accept) begin
         sig_d        = sig_next;
         sample_cnt_d = sample_cnt_q + 16'd1;
         if ((y_in == '0) && (zero_cnt_q != '1)) zero_cnt_d = zero_cnt_q + 16'd1;
         if (last_sample) pass_d = (sig_next == golden);
      end
   end

   always_comb begin
      busy       = (state_q == RUN);
      done       = (state_q == DONE);
      pass       = pass_q;
      signature  = sig_q;
      sample_cnt = sample_cnt_q;
      zero_cnt   = zero_cnt_q;
   end

endmodule

// File: tb/tb_ass13_resp_misr.sv
// Self-checking bench for ass13_resp_misr with WINDOW=4, comparing against a
// window-level reference computed from the accepted sample list.
module tb_ass13_resp_misr;

   localparam int unsigned W    = 4;
   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;
   localparam logic [31:0] ZERO_GOLD = 32'hC7B0424D;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [24:0] y_in = '0;
   logic        y_valid = 1'b0;
   logic [31:0] golden = '0;
   logic        busy, done, pass;
   logic [31:0] signature;
   logic [15:0] sample_cnt, zero_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [24:0] samp_q[$];
   int          gap_q[$];

   ass13_resp_misr #(.WINDOW(W), .POLY(POLY), .SEED(SEED)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .y_in       (y_in),
      .y_valid    (y_valid),
      .golden     (golden),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .signature  (signature),
      .sample_cnt (sample_cnt),
      .zero_cnt   (zero_cnt)
   );

   always #5 clk = ~clk;

   // Signature as polynomial arithmetic: multiply by x, reduce modulo POLY, add the sample.
   function automatic logic [31:0] ref_sig();
      logic [63:0] acc;
      acc = 64'(SEED);
      foreach (samp_q[i]) begin
         acc = acc * 2;
         if (acc >= 64'h1_0000_0000) acc = (acc - 64'h1_0000_0000) ^ 64'(POLY);
         acc = acc ^ 64'(samp_q[i]);
      end
      return acc[31:0];
   endfunction

   function automatic int ref_zero();
      int z = 0;
      foreach (samp_q[i]) if (samp_q[i] == 0 && z < 65535) z++;
      return z;
   endfunction

   function automatic int ref_gaps();
      int s = 0;
      foreach (gap_q[i]) s += gap_q[i];
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one window from samp_q/gap_q; optionally holds start during RUN
   // or restarts in the DONE cycle.
   task automatic run_window(input string nm, input logic [31:0] gold,
                             input bit start_in_run, input bit restart_in_done);
      int          edges;
      bit          early;
      logic [31:0] exp_sig;
      logic        exp_pass;
      int          exp_lat;
      exp_sig  = ref_sig();
      exp_pass = (exp_sig == gold);
      exp_lat  = int'(W) + ref_gaps();
      edges    = 0;
      early    = 1'b0;
      golden   = gold;
      start    = 1'b1;
      tick();
      start = start_in_run;
      n_cmp++;
      if (busy !== 1'b1 || sample_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL %s start: busy=%b cnt=%0d required busy=1 cnt=0", nm, busy, sample_cnt);
      end
      foreach (samp_q[i]) begin
         for (int g = 0; g < gap_q[i]; g++) begin
            y_valid = 1'b0;
            y_in    = 25'($urandom);
            tick();
            edges++;
            if (done) early = 1'b1;
         end
         y_valid = 1'b1;
         y_in    = samp_q[i];
         tick();
         edges++;
         if (done && i != samp_q.size() - 1) early = 1'b1;
      end
      y_valid = 1'b0;
      start   = 1'b0;
      y_in    = 25'($urandom);
      n_cmp++;
      if (early) begin
         n_bad++;
         $display("FAIL %s early_done: done seen before final sample, required none", nm);
      end
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s done: done=%b busy=%b required done=1 busy=0", nm, done, busy);
      end
      n_cmp++;
      if (edges !== exp_lat) begin
         n_bad++;
         $display("FAIL %s latency: %0d edges required %0d", nm, edges, exp_lat);
      end
      n_cmp++;
      if (signature !== exp_sig) begin
         n_bad++;
         $display("FAIL %s signature: %h required %h", nm, signature, exp_sig);
      end
      n_cmp++;
      if (pass !== exp_pass) begin
         n_bad++;
         $display("FAIL %s pass: %b required %b", nm, pass, exp_pass);
      end
      n_cmp++;
      if (sample_cnt !== 16'(W) || zero_cnt !== 16'(ref_zero())) begin
         n_bad++;
         $display("FAIL %s counts: sample=%0d zero=%0d required %0d %0d",
                  nm, sample_cnt, zero_cnt, W, ref_zero());
      end
      if (restart_in_done) begin
         start = 1'b1;
         tick();
         start = 1'b0;
         n_cmp++;
         if (busy !== 1'b1 || done !== 1'b0 || sample_cnt !== 16'd0 || zero_cnt !== 16'd0 ||
             signature !== SEED || pass !== 1'b0) begin
            n_bad++;
            $display("FAIL %s restart: busy=%b done=%b cnt=%0d zero=%0d sig=%h pass=%b required 1 0 0 0 %h 0",
                     nm, busy, done, sample_cnt, zero_cnt, signature, SEED, pass);
         end
      end else begin
         tick();
         tick();
         n_cmp++;
         if (done !== 1'b0 || busy !== 1'b0 || pass !== exp_pass || signature !== exp_sig ||
             sample_cnt !== 16'(W)) begin
            n_bad++;
            $display("FAIL %s idle_hold: done=%b busy=%b pass=%b sig=%h cnt=%0d required 0 0 %b %h %0d",
                     nm, done, busy, pass, signature, sample_cnt, exp_pass, exp_sig, W);
         end
      end
   endtask

   task automatic set_zero_window();
      samp_q.delete();
      gap_q.delete();
      for (int i = 0; i < int'(W); i++) begin
         samp_q.push_back('0);
         gap_q.push_back(0);
      end
   endtask

   task automatic set_random_window(input int max_gap);
      samp_q.delete();
      gap_q.delete();
      for (int i = 0; i < int'(W); i++) begin
         samp_q.push_back(($urandom_range(0, 3) == 0) ? 25'd0 : 25'($urandom));
         gap_q.push_back($urandom_range(0, max_gap));
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      tick();
      rst   = 1'b0;
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags: busy=%b done=%b pass=%b required 0 0 0", busy, done, pass);
      end
      n_cmp++;
      if (signature !== SEED) begin
         n_bad++;
         $display("FAIL reset_sig: %h required %h", signature, SEED);
      end
      n_cmp++;
      if (sample_cnt !== 16'd0 || zero_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_cnt: sample=%0d zero=%0d required 0 0", sample_cnt, zero_cnt);
      end
   endtask

   task automatic test_all_zero();
      set_zero_window();
      n_cmp++;
      if (ref_sig() !== ZERO_GOLD) begin
         n_bad++;
         $display("FAIL zero_model: %h required %h", ref_sig(), ZERO_GOLD);
      end
      run_window("all_zero", ZERO_GOLD, 1'b0, 1'b0);
      n_cmp++;
      if (signature !== ZERO_GOLD || pass !== 1'b1) begin
         n_bad++;
         $display("FAIL all_zero_const: sig=%h pass=%b required %h 1", signature, pass, ZERO_GOLD);
      end
   endtask

   task automatic test_valid_gaps();
      set_zero_window();
      gap_q[2] = 3;
      run_window("valid_gaps", ZERO_GOLD, 1'b0, 1'b0);
   endtask

   task automatic test_mismatch();
      set_zero_window();
      samp_q[1] = 25'h0000400;
      run_window("mismatch", ZERO_GOLD, 1'b0, 1'b0);
      n_cmp++;
      if (pass !== 1'b0 || zero_cnt !== 16'd3) begin
         n_bad++;
         $display("FAIL mismatch_const: pass=%b zero=%0d required 0 3", pass, zero_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen  = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         y_valid = 1'b1;
         y_in    = 25'($urandom);
         tick();
      end
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      y_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || signature !== SEED || sample_cnt !== 16'd0 ||
          zero_cnt !== 16'd0 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid: busy=%b done=%b sig=%h cnt=%0d zero=%0d pass=%b required 0 0 %h 0 0 0",
                  busy, done, signature, sample_cnt, zero_cnt, pass, SEED);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL reset_mid_quiet: done/busy seen after reset, required none");
      end
      set_random_window(1);
      run_window("after_reset", ref_sig(), 1'b0, 1'b0);
   endtask

   task automatic test_start_in_run();
      set_random_window(2);
      run_window("start_in_run", ref_sig(), 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      set_random_window(1);
      run_window("b2b_first", ref_sig() ^ 32'h1, 1'b0, 1'b1);
      set_random_window(1);
      run_window("b2b_second", ref_sig(), 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] gold;
      for (int n = 0; n < 12; n++) begin
         set_random_window(2);
         gold = ref_sig();
         if ($urandom_range(0, 1) == 0) gold = gold ^ (32'h1 << $urandom_range(0, 31));
         run_window($sformatf("random%0d", n), gold, 1'b0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_all_zero();
      test_valid_gaps();
      test_mismatch();
      test_reset_mid();
      test_start_in_run();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
